// File: rtl/result_sel_pkg.sv
// Shared types and helpers for the result selector pipeline: storage state
// encoding, the per-transfer item layout, flag computation and select width.
`define RESULT_SEL_ITEM_T(w) struct packed { logic [(w)-1:0] data; logic zero; logic neg; logic bad_sel; }

package result_sel_pkg;

  localparam int MAX_WIDTH = 1024;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Callers zero-extend their value to MAX_WIDTH; returns {zero, neg}.
  function automatic logic [1:0] calc_flags(input logic [MAX_WIDTH-1:0] data,
                                            input int width);
    return {data == '0, data[width-1]};
  endfunction

endpackage

// File: rtl/mux2_1.sv
// Two-input WIDTH-bit multiplexer used as one node of the select tree.
module mux2_1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/muxn.sv
// Combinational N:1 selector built as a binary tree of mux2_1 nodes; selects
// at or above N produce zero and raise bad_sel.
module muxn
  import result_sel_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 5,
  parameter int SELW  = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               bad_sel
);

  localparam int LEAVES = 2 ** SELW;

  // Level 0 is the root; level SELW holds the channels padded to a power of two.
  for (genvar d = 0; d <= SELW; d++) begin : g_lvl
    logic [WIDTH-1:0] node [2**d];
    if (d == SELW) begin : g_leaf
      for (genvar j = 0; j < LEAVES; j++) begin : g_in
        if (j < N) begin : g_used
          assign node[j] = in_data[j*WIDTH +: WIDTH];
        end else begin : g_pad
          assign node[j] = '0;
        end
      end
    end else begin : g_mux
      for (genvar j = 0; j < 2**d; j++) begin : g_m
        mux2_1 #(.WIDTH(WIDTH)) u_mux2 (
          .a   (g_lvl[d+1].node[2*j]),
          .b   (g_lvl[d+1].node[2*j+1]),
          .sel (sel[SELW-1-d]),
          .y   (node[j])
        );
      end
    end
  end

  assign bad_sel  = (int'(sel) >= N);
  assign out_data = bad_sel ? '0 : g_lvl[0].node[0];

endmodule

// File: rtl/result_sel_pipe.sv
// N-input result selector with flag generation, a registered output stage and
// a skid register so in_ready never depends combinationally on out_ready.
module result_sel_pipe
  import result_sel_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 5,
  parameter int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_bad_sel
);

  typedef `RESULT_SEL_ITEM_T(WIDTH) item_t;

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_bad;
  logic [MAX_WIDTH-1:0] sel_ext;
  logic [1:0]           sel_flags;
  item_t                new_item;

  state_e state_q, state_d;
  item_t  o_q, o_d;
  item_t  s_q, s_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, emit;

  muxn #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) u_muxn (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (sel_data),
    .bad_sel  (sel_bad)
  );

  always_comb begin
    sel_ext                = '0;
    sel_ext[WIDTH-1:0]     = sel_data;
    sel_flags              = calc_flags(sel_ext, WIDTH);
    new_item               = '{data: sel_data, zero: sel_flags[1],
                               neg: sel_flags[0], bad_sel: sel_bad};
  end

  // O always holds the oldest item; S only ever holds the second one.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    accept  = in_valid && in_ready_q;
    emit    = (state_q != ST_EMPTY) && out_ready;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          o_d     = new_item;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          o_d = new_item;
        end else if (accept) begin
          s_d     = new_item;
          state_d = ST_FULL;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          o_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      o_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = o_q.data;
  assign out_zero    = o_q.zero;
  assign out_neg     = o_q.neg;
  assign out_bad_sel = o_q.bad_sel;

endmodule

// File: tb/tb_result_sel_pipe.sv
// Bench for result_sel_pipe: directed checks on a 64-bit 5-input instance and a
// randomised queue-model scoreboard on an 8-bit 16-input instance.
module tb_result_sel_pipe;

  localparam int W_A = 64;
  localparam int N_A = 5;
  localparam int S_A = 3;
  localparam int W_B = 8;
  localparam int N_B = 16;
  localparam int S_B = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic               a_out_zero, a_out_neg, a_out_bad_sel;
  logic [N_A*W_A-1:0] a_in_data;
  logic [S_A-1:0]     a_in_sel;
  logic [W_A-1:0]     a_out_data;

  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic               b_out_zero, b_out_neg, b_out_bad_sel;
  logic [N_B*W_B-1:0] b_in_data;
  logic [S_B-1:0]     b_in_sel;
  logic [W_B-1:0]     b_out_data;

  result_sel_pipe #(.WIDTH(W_A), .N(N_A)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_zero(a_out_zero), .out_neg(a_out_neg), .out_bad_sel(a_out_bad_sel)
  );

  result_sel_pipe #(.WIDTH(W_B), .N(N_B)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_zero(b_out_zero), .out_neg(b_out_neg), .out_bad_sel(b_out_bad_sel)
  );

  int check_count = 0;
  int pass_count  = 0;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Every channel gets a distinct non-zero filler, then channel ch gets val.
  task automatic apply_stimulus_a(input logic v, input int sel, input int ch,
                                  input logic [63:0] val, input logic rdy);
    for (int k = 0; k < N_A; k++)
      a_in_data[k*W_A +: W_A] = (k == ch) ? val : (64'h1111_0000_0000_0000 + 64'(k + 1));
    a_in_valid  = v;
    a_in_sel    = S_A'(sel);
    a_out_ready = rdy;
  endtask

  // Reference item {data, zero, neg, bad_sel} derived from the selection rules.
  function automatic logic [10:0] ref_item(input logic [N_B*W_B-1:0] data, input int sel);
    int unsigned v;
    if (sel >= N_B) return {8'h00, 1'b1, 1'b0, 1'b1};
    v = int'((data >> (sel * W_B)) & 128'hFF);
    return {8'(v), v == 0, v >= 128, 1'b0};
  endfunction

  logic [10:0] model[$];
  logic        prev_stall;
  logic [10:0] prev_out;

  task automatic rand_cycle(input logic v, input logic r);
    logic [10:0] cur;
    logic [10:0] exp_item;
    b_in_valid  = v;
    b_out_ready = r;
    b_in_sel    = S_B'($urandom_range(0, N_B - 1));
    b_in_data   = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) b_in_data[b_in_sel*W_B +: W_B] = '0;
    #1;
    cur = {b_out_data, b_out_zero, b_out_neg, b_out_bad_sel};
    check_output("rand_out_valid", 64'(b_out_valid), 64'(model.size() > 0));
    check_output("rand_in_ready", 64'(b_in_ready), 64'(model.size() < 2));
    if (prev_stall) check_output("rand_stable", 64'(cur), 64'(prev_out));
    if (b_out_valid && b_out_ready) begin
      if (model.size() > 0) begin
        exp_item = model.pop_front();
        check_output("rand_item", 64'(cur), 64'(exp_item));
      end else begin
        check_output("rand_unexpected_emit", 64'(b_out_valid), 64'd0);
      end
    end
    if (b_in_valid && b_in_ready) model.push_back(ref_item(b_in_data, int'(b_in_sel)));
    prev_stall = b_out_valid && !b_out_ready;
    prev_out   = cur;
    @(negedge clk);
  endtask

  initial begin
    int          emits;
    int          low_cnt;
    logic [63:0] exp_next;

    reset_n    = 1'b0;
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    b_in_sel   = '0;
    b_in_data  = '0;
    prev_stall = 1'b0;
    prev_out   = '0;
    apply_stimulus_a(1'b1, 0, 0, 64'h1, 1'b1);
    #12;
    check_output("reset_out_valid", 64'(a_out_valid), 64'd0);
    check_output("reset_in_ready", 64'(a_in_ready), 64'd1);
    check_output("reset_out_data", a_out_data, 64'd0);
    check_output("reset_flags", {61'd0, a_out_zero, a_out_neg, a_out_bad_sel}, 64'd0);

    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus_a(1'b1, 3, 3, 64'h8000_0000_0000_0001, 1'b1);
    @(negedge clk);
    check_output("single_valid", 64'(a_out_valid), 64'd1);
    check_output("single_data", a_out_data, 64'h8000_0000_0000_0001);
    check_output("single_flags", {61'd0, a_out_zero, a_out_neg, a_out_bad_sel}, 64'b010);

    apply_stimulus_a(1'b1, 2, 2, 64'h0, 1'b1);
    @(negedge clk);
    check_output("zero_data", a_out_data, 64'd0);
    check_output("zero_flags", {61'd0, a_out_zero, a_out_neg, a_out_bad_sel}, 64'b100);

    apply_stimulus_a(1'b1, 6, 0, 64'h5, 1'b1);
    @(negedge clk);
    check_output("bad_data", a_out_data, 64'd0);
    check_output("bad_flags", {61'd0, a_out_zero, a_out_neg, a_out_bad_sel}, 64'b101);

    apply_stimulus_a(1'b0, 0, 0, 64'h1, 1'b1);
    @(negedge clk);
    check_output("drained_valid", 64'(a_out_valid), 64'd0);

    // Backpressure: 1 and 2 fill O and S, 3 waits until S drains.
    apply_stimulus_a(1'b1, 0, 0, 64'd1, 1'b0);
    @(negedge clk);
    check_output("bp_ready_1", 64'(a_in_ready), 64'd1);
    check_output("bp_data_1", a_out_data, 64'd1);
    apply_stimulus_a(1'b1, 0, 0, 64'd2, 1'b0);
    @(negedge clk);
    check_output("bp_ready_2", 64'(a_in_ready), 64'd0);
    check_output("bp_hold_a", a_out_data, 64'd1);
    apply_stimulus_a(1'b1, 0, 0, 64'd3, 1'b0);
    @(negedge clk);
    check_output("bp_ready_3", 64'(a_in_ready), 64'd0);
    check_output("bp_hold_b", a_out_data, 64'd1);
    apply_stimulus_a(1'b1, 0, 0, 64'd3, 1'b1);
    @(negedge clk);
    check_output("bp_emit_2", a_out_data, 64'd2);
    check_output("bp_ready_up", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    check_output("bp_emit_3", a_out_data, 64'd3);
    check_output("bp_valid_3", 64'(a_out_valid), 64'd1);
    apply_stimulus_a(1'b0, 0, 0, 64'd3, 1'b1);
    @(negedge clk);
    check_output("bp_no_dup", 64'(a_out_valid), 64'd0);

    emits    = 0;
    low_cnt  = 0;
    exp_next = 64'd1;
    for (int c = 0; c <= 100; c++) begin
      apply_stimulus_a(c < 100, 0, 0, 64'(c + 1), 1'b1);
      #1;
      if (!a_in_ready) low_cnt++;
      if (a_out_valid) begin
        check_output("tput_data", a_out_data, exp_next);
        exp_next++;
        emits++;
      end
      @(negedge clk);
    end
    check_output("tput_emits", 64'(emits), 64'd100);
    check_output("tput_ready_low", 64'(low_cnt), 64'd0);

    apply_stimulus_a(1'b1, 0, 0, 64'd7, 1'b0);
    @(negedge clk);
    apply_stimulus_a(1'b1, 0, 0, 64'd8, 1'b0);
    @(negedge clk);
    check_output("mid_full", 64'(a_in_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mid_async_valid", 64'(a_out_valid), 64'd0);
    check_output("mid_async_ready", 64'(a_in_ready), 64'd1);
    apply_stimulus_a(1'b1, 0, 0, 64'd9, 1'b1);
    @(negedge clk);
    check_output("mid_in_reset_valid", 64'(a_out_valid), 64'd0);
    reset_n = 1'b1;
    apply_stimulus_a(1'b1, 0, 0, 64'h55, 1'b1);
    @(negedge clk);
    check_output("mid_first_valid", 64'(a_out_valid), 64'd1);
    check_output("mid_first_data", a_out_data, 64'h55);
    apply_stimulus_a(1'b0, 0, 0, 64'h55, 1'b1);
    @(negedge clk);

    for (int c = 0; c < 400; c++)
      rand_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 4; c++)
      rand_cycle(1'b0, 1'b1);
    check_output("rand_drained", 64'(model.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
